// File: rtl/spi_pkg.sv
// -----------------------------------------------------------------------------
// spi_pkg
// Shared definitions for the SPI byte receiver: byte width, SPI mode and the
// derived clock polarity, the receiver state enum and a bit-order helper.
// No ports.
// -----------------------------------------------------------------------------
package spi_pkg;

  localparam int BYTE_W = 8;

  // Mode 0: CPOL=0, CPHA=0. Data is sampled on the leading edge and changed
  // on the trailing edge; with CPOL=0 the leading edge is the rising edge.
  localparam logic [1:0] SPI_MODE = 2'd0;
  localparam logic       SPI_CPOL = SPI_MODE[1];

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_t;

  // First bit to put on the wire for a byte in the selected bit order.
  function automatic logic first_bit(input logic [BYTE_W-1:0] b,
                                     input logic              msb_first);
    return msb_first ? b[BYTE_W-1] : b[0];
  endfunction

endpackage

// File: rtl/sync_ff.sv
// -----------------------------------------------------------------------------
// sync_ff
// Single-bit multi-stage synchronizer with a configurable reset value.
// Ports:
//   clk_device  in   sampling clock
//   reset_n     in   asynchronous active-low reset
//   i_d         in   asynchronous input
//   o_q         out  synchronised output (DEPTH cycles of latency)
// -----------------------------------------------------------------------------
module sync_ff #(
  parameter int   DEPTH   = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk_device,
  input  logic reset_n,
  input  logic i_d,
  output logic o_q
);

  logic [DEPTH-1:0] r_stage;

  always_ff @(posedge clk_device or negedge reset_n) begin
    if (!reset_n) begin
      r_stage <= {DEPTH{RST_VAL}};
    end else begin
      r_stage <= {r_stage[DEPTH-2:0], i_d};
    end
  end

  assign o_q = r_stage[DEPTH-1];

endmodule

// File: rtl/spi_byte_receiver.sv
// -----------------------------------------------------------------------------
// spi_byte_receiver
// SPI mode-0 slave front end. Oversamples SCK/MOSI/CS_n on clk_device,
// assembles MOSI bytes, strobes each completed byte to the command controller,
// shifts a response byte out on MISO and flags frames that end mid-byte.
//
//   state  | meaning
//   -------+---------------------------------------------------------------
//   IDLE   | deselected; bit counter zero, MISO high, SCK edges ignored
//   ACTIVE | selected; shift MOSI on SCK rise, advance MISO on SCK fall
//
// Ports:
//   clk_device        in   oversampling clock (>= 4x SCK)
//   reset_n           in   asynchronous active-low reset
//   spi_sck           in   SPI clock (async)
//   spi_mosi          in   SPI data in (async)
//   spi_cs_n          in   SPI chip select, active low (async)
//   spi_miso          out  SPI data out, 1 while deselected
//   data_out[7:0]     out  last completed byte
//   data_out_ready    out  one-cycle strobe, data_out is new
//   cs_n_out          out  synchronised chip select
//   tx_data[7:0]      in   response byte for the next byte slot
//   tx_load           in   one-cycle qualifier for tx_data
//   frame_byte_count  out  bytes completed in the current frame, saturating
//   frame_error       out  one-cycle pulse, CS rose with 1-7 bits received
// -----------------------------------------------------------------------------
module spi_byte_receiver
  import spi_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter bit MSB_FIRST   = 1'b1
) (
  input  logic        clk_device,
  input  logic        reset_n,
  input  logic        spi_sck,
  input  logic        spi_mosi,
  input  logic        spi_cs_n,
  output logic        spi_miso,
  output logic [7:0]  data_out,
  output logic        data_out_ready,
  output logic        cs_n_out,
  input  logic [7:0]  tx_data,
  input  logic        tx_load,
  output logic [7:0]  frame_byte_count,
  output logic        frame_error
);

  localparam logic [3:0] FLUSH_INIT = 4'(SYNC_STAGES);

  logic w_sck_s;
  logic w_mosi_s;
  logic w_cs_s;

  logic r_sck_d;
  logic r_cs_d;

  logic w_sck_lead;
  logic w_sck_trail;
  logic w_cs_fall;
  logic w_cs_rise;

  logic [3:0] r_flush_cnt;
  logic       r_cs_armed;

  state_t r_state;
  state_t w_state_next;

  logic [2:0]        r_bit_cnt;
  logic [BYTE_W-1:0] r_rx_shift;
  logic [BYTE_W-1:0] r_tx_shift;
  logic [BYTE_W-1:0] r_tx_pend;
  logic [BYTE_W-1:0] r_data_out;
  logic [7:0]        r_frame_byte_count;
  logic              r_data_out_ready;
  logic              r_frame_error;
  logic              r_miso;
  logic              r_byte_done;

  logic [BYTE_W-1:0] w_rx_next;
  logic [BYTE_W-1:0] w_tx_shift_next;
  logic              w_tx_next_bit;
  logic              w_last_bit;
  logic              w_partial;
  logic              w_tx_consume;

  sync_ff #(.DEPTH(SYNC_STAGES), .RST_VAL(SPI_CPOL)) u_sync_sck (
    .clk_device (clk_device),
    .reset_n    (reset_n),
    .i_d        (spi_sck),
    .o_q        (w_sck_s)
  );

  sync_ff #(.DEPTH(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
    .clk_device (clk_device),
    .reset_n    (reset_n),
    .i_d        (spi_mosi),
    .o_q        (w_mosi_s)
  );

  sync_ff #(.DEPTH(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cs (
    .clk_device (clk_device),
    .reset_n    (reset_n),
    .i_d        (spi_cs_n),
    .o_q        (w_cs_s)
  );

  always_ff @(posedge clk_device or negedge reset_n) begin
    if (!reset_n) begin
      r_sck_d <= SPI_CPOL;
      r_cs_d  <= 1'b1;
    end else begin
      r_sck_d <= w_sck_s;
      r_cs_d  <= w_cs_s;
    end
  end

  // After reset the synchronizer still holds its reset value (CS high), so a
  // CS pin already held low would look like a fresh falling edge. The CS fall
  // detector is only armed once the flushed synchronizer has shown CS high.
  always_ff @(posedge clk_device or negedge reset_n) begin
    if (!reset_n) begin
      r_flush_cnt <= FLUSH_INIT;
      r_cs_armed  <= 1'b0;
    end else begin
      if (r_flush_cnt != 4'd0) begin
        r_flush_cnt <= r_flush_cnt - 4'd1;
      end
      if ((r_flush_cnt == 4'd0) && w_cs_s) begin
        r_cs_armed <= 1'b1;
      end
    end
  end

  assign w_sck_lead  = (w_sck_s != r_sck_d) && (w_sck_s != SPI_CPOL);
  assign w_sck_trail = (w_sck_s != r_sck_d) && (w_sck_s == SPI_CPOL);
  assign w_cs_fall   = r_cs_armed && r_cs_d && !w_cs_s;
  assign w_cs_rise   = w_cs_s && !r_cs_d;

  assign w_rx_next = MSB_FIRST ? {r_rx_shift[BYTE_W-2:0], w_mosi_s}
                               : {w_mosi_s, r_rx_shift[BYTE_W-1:1]};

  assign w_tx_shift_next = MSB_FIRST ? {r_tx_shift[BYTE_W-2:0], 1'b0}
                                     : {1'b0, r_tx_shift[BYTE_W-1:1]};
  assign w_tx_next_bit   = MSB_FIRST ? r_tx_shift[BYTE_W-2] : r_tx_shift[1];

  assign w_last_bit = w_sck_lead && (r_bit_cnt == 3'd7);

  // Bits in hand when CS rises include a leading edge seen in the same cycle;
  // exactly 8 (a byte completing as CS rises) is discarded silently.
  assign w_partial = ((r_bit_cnt != 3'd0) || w_sck_lead) && !w_last_bit;

  assign w_tx_consume = ((r_state == IDLE) && w_cs_fall) ||
                        ((r_state == ACTIVE) && !w_cs_rise && w_sck_trail && r_byte_done);

  always_ff @(posedge clk_device or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (w_cs_fall) w_state_next = ACTIVE;
      ACTIVE:  if (w_cs_rise) w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_device or negedge reset_n) begin
    if (!reset_n) begin
      r_bit_cnt          <= '0;
      r_rx_shift         <= '0;
      r_tx_shift         <= '0;
      r_tx_pend          <= '0;
      r_data_out         <= '0;
      r_frame_byte_count <= '0;
      r_data_out_ready   <= 1'b0;
      r_frame_error      <= 1'b0;
      r_miso             <= 1'b1;
      r_byte_done        <= 1'b0;
    end else begin
      r_data_out_ready <= 1'b0;
      r_frame_error    <= 1'b0;

      // A load in the same cycle as consumption wins, so it lands in the
      // following byte slot instead of being lost.
      if (tx_load) begin
        r_tx_pend <= tx_data;
      end else if (w_tx_consume) begin
        r_tx_pend <= '0;
      end

      case (r_state)
        IDLE: begin
          r_bit_cnt <= '0;
          if (w_cs_fall) begin
            r_frame_byte_count <= '0;
            r_tx_shift         <= r_tx_pend;
            r_miso             <= first_bit(r_tx_pend, MSB_FIRST);
            r_byte_done        <= 1'b0;
          end
        end

        ACTIVE: begin
          if (w_cs_rise) begin
            r_frame_error <= w_partial;
            r_bit_cnt     <= '0;
            r_byte_done   <= 1'b0;
            r_miso        <= 1'b1;
          end else begin
            if (w_sck_lead) begin
              r_rx_shift <= w_rx_next;
              r_bit_cnt  <= r_bit_cnt + 3'd1;
              if (w_last_bit) begin
                r_data_out       <= w_rx_next;
                r_data_out_ready <= 1'b1;
                r_byte_done      <= 1'b1;
                if (r_frame_byte_count != 8'hFF) begin
                  r_frame_byte_count <= r_frame_byte_count + 8'd1;
                end
              end
            end

            // The trailing edge after a byte boundary starts the next response
            // byte; every other trailing edge advances the current one.
            if (w_sck_trail) begin
              if (r_byte_done) begin
                r_tx_shift  <= r_tx_pend;
                r_miso      <= first_bit(r_tx_pend, MSB_FIRST);
                r_byte_done <= 1'b0;
              end else begin
                r_tx_shift <= w_tx_shift_next;
                r_miso     <= w_tx_next_bit;
              end
            end
          end
        end

        default: begin
          r_bit_cnt <= '0;
        end
      endcase
    end
  end

  assign spi_miso         = r_miso;
  assign data_out         = r_data_out;
  assign data_out_ready   = r_data_out_ready;
  assign cs_n_out         = w_cs_s;
  assign frame_byte_count = r_frame_byte_count;
  assign frame_error      = r_frame_error;

endmodule

// File: tb/tb_spi_byte_receiver.sv
// -----------------------------------------------------------------------------
// tb_spi_byte_receiver
// Directed bench for spi_byte_receiver. The SPI master runs SCK at clk/8.
// Expected MOSI bytes and MISO bytes are queued by the stimulus; a monitor
// compares them as the DUT strobes data_out or the master finishes a byte.
// -----------------------------------------------------------------------------
module tb_spi_byte_receiver;

  logic       clk_device = 1'b0;
  logic       reset_n    = 1'b0;
  logic       spi_sck    = 1'b0;
  logic       spi_mosi   = 1'b0;
  logic       spi_cs_n   = 1'b1;
  logic       spi_miso;
  logic [7:0] data_out;
  logic       data_out_ready;
  logic       cs_n_out;
  logic [7:0] tx_data    = 8'h00;
  logic       tx_load    = 1'b0;
  logic [7:0] frame_byte_count;
  logic       frame_error;

  spi_byte_receiver #(.SYNC_STAGES(2), .MSB_FIRST(1'b1)) dut (
    .clk_device       (clk_device),
    .reset_n          (reset_n),
    .spi_sck          (spi_sck),
    .spi_mosi         (spi_mosi),
    .spi_cs_n         (spi_cs_n),
    .spi_miso         (spi_miso),
    .data_out         (data_out),
    .data_out_ready   (data_out_ready),
    .cs_n_out         (cs_n_out),
    .tx_data          (tx_data),
    .tx_load          (tx_load),
    .frame_byte_count (frame_byte_count),
    .frame_error      (frame_error)
  );

  always #5 clk_device = ~clk_device;

  int n_checks  = 0;
  int n_fail    = 0;
  int fe_pulses = 0;

  logic [7:0] exp_rx[$];
  logic [7:0] exp_miso[$];
  logic [7:0] obs_miso[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  // Monitor: data_out strobes against the expected-byte queue, MISO bytes
  // captured by the master against the expected-response queue.
  always @(negedge clk_device) begin
    if (frame_error === 1'b1) fe_pulses++;
    if (data_out_ready === 1'b1) begin
      if (exp_rx.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_strobe actual=0x%0h required=none", data_out);
      end else begin
        check("rx_byte", {24'h0, data_out}, {24'h0, exp_rx.pop_front()});
      end
    end
    if (obs_miso.size() > 0) begin
      if (exp_miso.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_miso actual=0x%0h required=none", obs_miso.pop_front());
      end else begin
        check("miso_byte", {24'h0, obs_miso.pop_front()}, {24'h0, exp_miso.pop_front()});
      end
    end
  end

  // Master shifts nbits of mosi_b MSB first; samples MISO just before each
  // rising SCK. Optionally pulses tx_load at the start of bit load_bit.
  task automatic xfer(input logic [7:0] mosi_b, input int nbits, input bit chk_miso,
                      input int load_bit, input logic [7:0] load_val);
    logic [7:0] m;
    m = 8'h00;
    for (int i = 0; i < nbits; i++) begin
      spi_mosi = mosi_b[7-i];
      if (i == load_bit) begin
        tx_data = load_val;
        tx_load = 1'b1;
        @(negedge clk_device);
        tx_load = 1'b0;
        repeat (3) @(negedge clk_device);
      end else begin
        repeat (4) @(negedge clk_device);
      end
      m = {m[6:0], spi_miso};
      spi_sck = 1'b1;
      repeat (4) @(negedge clk_device);
      spi_sck = 1'b0;
    end
    if (chk_miso && nbits == 8) obs_miso.push_back(m);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic [7:0] miso_req);
    exp_rx.push_back(b);
    exp_miso.push_back(miso_req);
    xfer(b, 8, 1'b1, -1, 8'h00);
  endtask

  task automatic start_frame();
    spi_cs_n = 1'b0;
    repeat (2) @(negedge clk_device);
  endtask

  task automatic end_frame();
    repeat (4) @(negedge clk_device);
    spi_cs_n = 1'b1;
    repeat (10) @(negedge clk_device);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_data_out"},       {24'h0, data_out},         32'h00);
    check({tag, "_ready"},          {31'h0, data_out_ready},   32'h0);
    check({tag, "_cs_n_out"},       {31'h0, cs_n_out},         32'h1);
    check({tag, "_miso"},           {31'h0, spi_miso},         32'h1);
    check({tag, "_frame_count"},    {24'h0, frame_byte_count}, 32'h00);
    check({tag, "_frame_error"},    {31'h0, frame_error},      32'h0);
  endtask

  int fe0;

  initial begin
    repeat (3) @(negedge clk_device);
    check_reset_values("reset");
    reset_n = 1'b1;
    repeat (10) @(negedge clk_device);

    // Single byte, plus cs_n_out latency of two clocks after the pin.
    spi_cs_n = 1'b0;
    @(negedge clk_device);
    check("cs_n_out_lat1", {31'h0, cs_n_out}, 32'h1);
    @(negedge clk_device);
    check("cs_n_out_lat2", {31'h0, cs_n_out}, 32'h0);
    send_byte(8'h0A, 8'h00);
    repeat (4) @(negedge clk_device);
    check("single_count", {24'h0, frame_byte_count}, 32'd1);
    end_frame();

    // Multi-byte frame.
    fe0 = fe_pulses;
    start_frame();
    send_byte(8'h0A, 8'h00);
    send_byte(8'h00, 8'h00);
    send_byte(8'h00, 8'h00);
    send_byte(8'h12, 8'h00);
    send_byte(8'h34, 8'h00);
    send_byte(8'hAB, 8'h00);
    send_byte(8'hCD, 8'h00);
    repeat (4) @(negedge clk_device);
    check("multi_count", {24'h0, frame_byte_count}, 32'd7);
    end_frame();
    check("multi_no_error", fe_pulses, fe0);

    // Truncated byte: 5 rising edges then CS high.
    fe0 = fe_pulses;
    start_frame();
    xfer(8'hF0, 5, 1'b0, -1, 8'h00);
    end_frame();
    check("trunc_error_once", fe_pulses, fe0 + 1);
    start_frame();
    send_byte(8'h5A, 8'h00);
    end_frame();
    check("trunc_next_ok", exp_rx.size(), 0);

    // MISO responses: preload before CS, reload mid-frame.
    tx_data = 8'hA5;
    tx_load = 1'b1;
    @(negedge clk_device);
    tx_load = 1'b0;
    start_frame();
    send_byte(8'h11, 8'hA5);
    exp_rx.push_back(8'h22);
    exp_miso.push_back(8'h00);
    xfer(8'h22, 8, 1'b1, 3, 8'h3C);
    send_byte(8'h33, 8'h3C);
    send_byte(8'h44, 8'h00);
    end_frame();

    // Saturation over a 300-byte frame.
    start_frame();
    for (int i = 0; i < 300; i++) begin
      logic [7:0] bv;
      bv = 8'(i) ^ 8'h5A;
      send_byte(bv, 8'h00);
    end
    repeat (4) @(negedge clk_device);
    check("sat_count", {24'h0, frame_byte_count}, 32'd255);
    end_frame();

    // CS rise coincident with the 8th rising edge: no strobe, no error.
    fe0 = fe_pulses;
    start_frame();
    send_byte(8'h77, 8'h00);
    xfer(8'h99, 7, 1'b0, -1, 8'h00);
    spi_mosi = 1'b1;
    repeat (4) @(negedge clk_device);
    spi_sck  = 1'b1;
    spi_cs_n = 1'b1;
    repeat (4) @(negedge clk_device);
    spi_sck = 1'b0;
    repeat (10) @(negedge clk_device);
    check("coinc_no_error", fe_pulses, fe0);
    check("coinc_count", {24'h0, frame_byte_count}, 32'd1);

    // Reset mid-byte with CS held low; must stay idle until a fresh CS fall.
    start_frame();
    send_byte(8'h81, 8'h00);
    xfer(8'hFF, 3, 1'b0, -1, 8'h00);
    reset_n = 1'b0;
    repeat (2) @(negedge clk_device);
    check_reset_values("midreset");
    fe0 = fe_pulses;
    reset_n = 1'b1;
    repeat (4) @(negedge clk_device);
    exp_miso.push_back(8'hFF);
    xfer(8'hE7, 8, 1'b1, -1, 8'h00);
    check("postreset_count", {24'h0, frame_byte_count}, 32'd0);
    spi_cs_n = 1'b1;
    repeat (10) @(negedge clk_device);
    check("postreset_no_error", fe_pulses, fe0);
    start_frame();
    send_byte(8'hC3, 8'h00);
    repeat (4) @(negedge clk_device);
    check("fresh_frame_count", {24'h0, frame_byte_count}, 32'd1);
    end_frame();

    repeat (4) @(negedge clk_device);
    check("rx_queue_drained", exp_rx.size(), 0);
    check("miso_queue_drained", exp_miso.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
